// File: rtl/frame_sequencer.sv
// Per-frame scheduler for the two player calculators: waits for both, resolves hits, commits the
// authoritative player registers and sequences round end, scoring and round restart.
module frame_sequencer #(
   parameter int unsigned STATE_DEPTH        = 3,
   parameter int unsigned SPRITE_INDEX_DEPTH = 3,
   parameter int unsigned POSITION_DEPTH     = 10,
   parameter int unsigned PLAYER_WIDTH       = 64,
   parameter int unsigned CALC_TIMEOUT       = 15,
   parameter int unsigned KICK_RANGE         = 40,
   parameter int unsigned GRAB_RANGE         = 8,
   parameter int unsigned KICK_ACTIVE_FRAME  = 2,
   parameter int unsigned GRAB_ACTIVE_FRAME  = 1,
   parameter int unsigned ROUND_END_FRAMES   = 60,
   parameter int unsigned P1_START_POS       = 100,
   parameter int unsigned P2_START_POS       = 500,
   parameter int unsigned SCORE_DEPTH        = 4,
   parameter int unsigned ST_NOTHING         = 0,
   parameter int unsigned ST_KICK            = 1,
   parameter int unsigned ST_GRAB            = 2,
   parameter int unsigned ST_BLOCK           = 3,
   parameter int unsigned ST_WIN             = 4,
   parameter int unsigned ST_LOSE            = 5
) (
   input  logic                          sys_clk,
   input  logic                          reset,
   input  logic                          frame_clk,
   input  logic                          p1_done,
   input  logic                          p2_done,
   input  logic [STATE_DEPTH-1:0]        p1_next_state,
   input  logic [STATE_DEPTH-1:0]        p2_next_state,
   input  logic [SPRITE_INDEX_DEPTH-1:0] p1_next_sprite,
   input  logic [SPRITE_INDEX_DEPTH-1:0] p2_next_sprite,
   input  logic [POSITION_DEPTH-1:0]     p1_next_pos,
   input  logic [POSITION_DEPTH-1:0]     p2_next_pos,
   output logic [STATE_DEPTH-1:0]        p1_state,
   output logic [STATE_DEPTH-1:0]        p2_state,
   output logic [SPRITE_INDEX_DEPTH-1:0] p1_sprite,
   output logic [SPRITE_INDEX_DEPTH-1:0] p2_sprite,
   output logic [POSITION_DEPTH-1:0]     p1_pos,
   output logic [POSITION_DEPTH-1:0]     p2_pos,
   output logic                          p1_hit,
   output logic                          p2_hit,
   output logic                          frame_commit,
   output logic                          round_over,
   output logic                          round_start,
   output logic [SCORE_DEPTH-1:0]        p1_score,
   output logic [SCORE_DEPTH-1:0]        p2_score,
   output logic                          calc_timeout,
   output logic                          frame_overrun
);

   localparam int unsigned CNT_W = $clog2(CALC_TIMEOUT + 1);
   localparam int unsigned RND_W = $clog2(ROUND_END_FRAMES + 1);
   localparam int unsigned GAP_W = POSITION_DEPTH + 2;

   localparam logic [STATE_DEPTH-1:0] S_NOTHING = STATE_DEPTH'(ST_NOTHING);
   localparam logic [STATE_DEPTH-1:0] S_KICK    = STATE_DEPTH'(ST_KICK);
   localparam logic [STATE_DEPTH-1:0] S_GRAB    = STATE_DEPTH'(ST_GRAB);
   localparam logic [STATE_DEPTH-1:0] S_BLOCK   = STATE_DEPTH'(ST_BLOCK);
   localparam logic [STATE_DEPTH-1:0] S_WIN     = STATE_DEPTH'(ST_WIN);
   localparam logic [STATE_DEPTH-1:0] S_LOSE    = STATE_DEPTH'(ST_LOSE);

   localparam logic [SPRITE_INDEX_DEPTH-1:0] KICK_SPR = SPRITE_INDEX_DEPTH'(KICK_ACTIVE_FRAME);
   localparam logic [SPRITE_INDEX_DEPTH-1:0] GRAB_SPR = SPRITE_INDEX_DEPTH'(GRAB_ACTIVE_FRAME);
   localparam logic [POSITION_DEPTH-1:0]     P1_START = POSITION_DEPTH'(P1_START_POS);
   localparam logic [POSITION_DEPTH-1:0]     P2_START = POSITION_DEPTH'(P2_START_POS);
   localparam logic [CNT_W-1:0]              CALC_LIMIT = CNT_W'(CALC_TIMEOUT);
   localparam logic [RND_W-1:0]              RND_LAST   = RND_W'(ROUND_END_FRAMES - 1);
   localparam logic [GAP_W-1:0]              KICK_GAP   = GAP_W'(KICK_RANGE);
   localparam logic [GAP_W-1:0]              GRAB_GAP   = GAP_W'(GRAB_RANGE);

   typedef enum logic [2:0] {
      StIdle,
      StCalc,
      StResolve,
      StCommit,
      StRoundEnd,
      StRestart
   } state_e;

   state_e                          state_q, state_d;
   logic [2:0]                      sync_q;
   logic                            fedge_q;
   logic [CNT_W-1:0]                calc_cnt_q;
   logic [RND_W-1:0]                round_cnt_q;
   logic [STATE_DEPTH-1:0]          p1_state_q, p2_state_q;
   logic [SPRITE_INDEX_DEPTH-1:0]   p1_sprite_q, p2_sprite_q;
   logic [POSITION_DEPTH-1:0]       p1_pos_q, p2_pos_q;
   logic                            p1_hit_q, p2_hit_q;
   logic                            frame_commit_q, round_start_q;
   logic [SCORE_DEPTH-1:0]          p1_score_q, p2_score_q;
   logic                            calc_timeout_q, frame_overrun_q;

   logic                            calc_done, timeout_hit, round_end_hit;
   logic                            p1_win, p2_win;
   logic [GAP_W-1:0]                diff, gap;
   logic                            p1_lands, p2_lands;

   assign calc_done   = p1_done & p2_done;
   assign timeout_hit = (calc_cnt_q == CALC_LIMIT);
   assign p1_win      = (p1_next_state == S_WIN);
   assign p2_win      = (p2_next_state == S_WIN);
   assign round_end_hit = p1_win | p2_win | (p1_next_state == S_LOSE) |
                          (p2_next_state == S_LOSE);

   // Extra headroom bit makes an overlap (negative gap) visible as the sign bit.
   assign diff = GAP_W'(p2_next_pos) - GAP_W'(p1_next_pos) - GAP_W'(PLAYER_WIDTH);
   assign gap  = diff[GAP_W-1] ? '0 : diff;

   assign p1_lands =
      ((p1_next_state == S_KICK) && (p1_next_sprite == KICK_SPR) && (gap <= KICK_GAP) &&
       (p2_next_state != S_BLOCK)) ||
      ((p1_next_state == S_GRAB) && (p1_next_sprite == GRAB_SPR) && (gap <= GRAB_GAP));
   assign p2_lands =
      ((p2_next_state == S_KICK) && (p2_next_sprite == KICK_SPR) && (gap <= KICK_GAP) &&
       (p1_next_state != S_BLOCK)) ||
      ((p2_next_state == S_GRAB) && (p2_next_sprite == GRAB_SPR) && (gap <= GRAB_GAP));

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:     if (fedge_q) state_d = StCalc;
         StCalc:     if (calc_done || timeout_hit) state_d = StResolve;
         StResolve:  state_d = StCommit;
         StCommit:   state_d = round_end_hit ? StRoundEnd : StIdle;
         StRoundEnd: if (fedge_q && (round_cnt_q == RND_LAST)) state_d = StRestart;
         StRestart:  state_d = StIdle;
         default:    state_d = StIdle;
      endcase
   end

   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset) begin
         sync_q          <= '0;
         fedge_q         <= 1'b0;
         calc_cnt_q      <= '0;
         round_cnt_q     <= '0;
         p1_state_q      <= S_NOTHING;
         p2_state_q      <= S_NOTHING;
         p1_sprite_q     <= '0;
         p2_sprite_q     <= '0;
         p1_pos_q        <= P1_START;
         p2_pos_q        <= P2_START;
         p1_hit_q        <= 1'b0;
         p2_hit_q        <= 1'b0;
         frame_commit_q  <= 1'b0;
         round_start_q   <= 1'b0;
         p1_score_q      <= '0;
         p2_score_q      <= '0;
         calc_timeout_q  <= 1'b0;
         frame_overrun_q <= 1'b0;
      end else begin
         sync_q         <= {sync_q[1:0], frame_clk};
         fedge_q        <= sync_q[1] & ~sync_q[2];
         frame_commit_q <= 1'b0;
         round_start_q  <= 1'b0;

         if (state_q == StCalc) calc_cnt_q <= calc_cnt_q + 1'b1;
         else                   calc_cnt_q <= '0;

         if (state_q == StCommit)                round_cnt_q <= '0;
         else if (state_q == StRoundEnd && fedge_q) round_cnt_q <= round_cnt_q + 1'b1;

         if (state_q == StCalc && timeout_hit && !calc_done) calc_timeout_q <= 1'b1;
         if (fedge_q && (state_q inside {StCalc, StResolve, StCommit, StRestart})) begin
            frame_overrun_q <= 1'b1;
         end

         // Simultaneous landings cancel out.
         if (state_q == StResolve) begin
            p1_hit_q <= p1_lands & ~p2_lands;
            p2_hit_q <= p2_lands & ~p1_lands;
         end

         if (state_q == StCommit) begin
            p1_state_q     <= p1_next_state;
            p2_state_q     <= p2_next_state;
            p1_sprite_q    <= p1_next_sprite;
            p2_sprite_q    <= p2_next_sprite;
            p1_pos_q       <= p1_next_pos;
            p2_pos_q       <= p2_next_pos;
            frame_commit_q <= 1'b1;
            if (p1_win && !p2_win && (p1_score_q != '1)) p1_score_q <= p1_score_q + 1'b1;
            if (p2_win && !p1_win && (p2_score_q != '1)) p2_score_q <= p2_score_q + 1'b1;
         end

         if (state_q == StRestart) begin
            p1_state_q    <= S_NOTHING;
            p2_state_q    <= S_NOTHING;
            p1_sprite_q   <= '0;
            p2_sprite_q   <= '0;
            p1_pos_q      <= P1_START;
            p2_pos_q      <= P2_START;
            p1_hit_q      <= 1'b0;
            p2_hit_q      <= 1'b0;
            round_start_q <= 1'b1;
         end
      end
   end

   assign p1_state      = p1_state_q;
   assign p2_state      = p2_state_q;
   assign p1_sprite     = p1_sprite_q;
   assign p2_sprite     = p2_sprite_q;
   assign p1_pos        = p1_pos_q;
   assign p2_pos        = p2_pos_q;
   assign p1_hit        = p1_hit_q;
   assign p2_hit        = p2_hit_q;
   assign frame_commit  = frame_commit_q;
   assign round_over    = (state_q == StRoundEnd);
   assign round_start   = round_start_q;
   assign p1_score      = p1_score_q;
   assign p2_score      = p2_score_q;
   assign calc_timeout  = calc_timeout_q;
   assign frame_overrun = frame_overrun_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: table of frames scored through a commit queue, then round sequencing,
// score saturation and reset-in-round.
module tb_frame_sequencer;

   localparam int NOTHING = 0, KICK = 1, GRAB = 2, BLOCK = 3, WIN = 4, LOSE = 5;
   localparam int NEVER = 99;

   logic       sys_clk = 1'b0;
   logic       reset = 1'b0;
   logic       frame_clk = 1'b0;
   logic       p1_done = 1'b0, p2_done = 1'b0;
   logic [2:0] p1_next_state = '0, p2_next_state = '0;
   logic [2:0] p1_next_sprite = '0, p2_next_sprite = '0;
   logic [9:0] p1_next_pos = 10'd100, p2_next_pos = 10'd500;
   logic [2:0] p1_state, p2_state, p1_sprite, p2_sprite;
   logic [9:0] p1_pos, p2_pos;
   logic       p1_hit, p2_hit, frame_commit, round_over, round_start;
   logic [3:0] p1_score, p2_score;
   logic       calc_timeout, frame_overrun;

   frame_sequencer dut (
      .sys_clk        (sys_clk),
      .reset          (reset),
      .frame_clk      (frame_clk),
      .p1_done        (p1_done),
      .p2_done        (p2_done),
      .p1_next_state  (p1_next_state),
      .p2_next_state  (p2_next_state),
      .p1_next_sprite (p1_next_sprite),
      .p2_next_sprite (p2_next_sprite),
      .p1_next_pos    (p1_next_pos),
      .p2_next_pos    (p2_next_pos),
      .p1_state       (p1_state),
      .p2_state       (p2_state),
      .p1_sprite      (p1_sprite),
      .p2_sprite      (p2_sprite),
      .p1_pos         (p1_pos),
      .p2_pos         (p2_pos),
      .p1_hit         (p1_hit),
      .p2_hit         (p2_hit),
      .frame_commit   (frame_commit),
      .round_over     (round_over),
      .round_start    (round_start),
      .p1_score       (p1_score),
      .p2_score       (p2_score),
      .calc_timeout   (calc_timeout),
      .frame_overrun  (frame_overrun)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      logic [2:0] s1, sp1;
      logic [9:0] pos1;
      logic [2:0] s2, sp2;
      logic [9:0] pos2;
      int         d1, d2;
      bit         ovr_tick, h1, h2, tmo, ovr;
   } vec_t;

   typedef struct {
      logic [2:0] s1, sp1;
      logic [9:0] pos1;
      logic [2:0] s2, sp2;
      logic [9:0] pos2;
      bit         h1, h2;
      int         lat;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   vec_t tbl[14];
   int   checks = 0, failures = 0;
   int   cyc = 0, rise_cyc = 0, rs_cnt = 0;

   always @(posedge sys_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic vec_t mk(int s1, int sp1, int pos1, int s2, int sp2, int pos2, int d1,
                               int d2, bit ot, bit h1, bit h2, bit tmo, bit ovr);
      vec_t v;
      v.s1 = 3'(s1); v.sp1 = 3'(sp1); v.pos1 = 10'(pos1);
      v.s2 = 3'(s2); v.sp2 = 3'(sp2); v.pos2 = 10'(pos2);
      v.d1 = d1; v.d2 = d2; v.ovr_tick = ot;
      v.h1 = h1; v.h2 = h2; v.tmo = tmo; v.ovr = ovr;
      return v;
   endfunction

   // Commit monitor: every frame_commit must match the oldest outstanding frame.
   always @(negedge sys_clk) begin
      if (reset) begin
         if (round_start) rs_cnt++;
         if (frame_commit) begin
            if (sb.size() == 0) begin
               chk("unexpected_commit", 32'd1, 32'd0);
            end else begin
               mon_e = sb.pop_front();
               chk("commit_p1_state", p1_state, mon_e.s1);
               chk("commit_p1_sprite", p1_sprite, mon_e.sp1);
               chk("commit_p1_pos", p1_pos, mon_e.pos1);
               chk("commit_p2_state", p2_state, mon_e.s2);
               chk("commit_p2_sprite", p2_sprite, mon_e.sp2);
               chk("commit_p2_pos", p2_pos, mon_e.pos2);
               chk("commit_p1_hit", p1_hit, mon_e.h1);
               chk("commit_p2_hit", p2_hit, mon_e.h2);
               chk("commit_latency", cyc - rise_cyc, mon_e.lat);
            end
         end
      end
   end

   task automatic run_frame(input vec_t v, input string tag);
      exp_t e;
      int   k;
      @(negedge sys_clk);
      p1_next_state = v.s1; p1_next_sprite = v.sp1; p1_next_pos = v.pos1;
      p2_next_state = v.s2; p2_next_sprite = v.sp2; p2_next_pos = v.pos2;
      p1_done = 1'b0; p2_done = 1'b0;
      k = (v.d1 > v.d2) ? v.d1 : v.d2;
      if (k < 1) k = 1;
      if (k > 16) k = 16;
      // 3 cycles sync + edge, then IDLE->CALC, CALC, RESOLVE, COMMIT.
      e.s1 = v.s1; e.sp1 = v.sp1; e.pos1 = v.pos1;
      e.s2 = v.s2; e.sp2 = v.sp2; e.pos2 = v.pos2;
      e.h1 = v.h1; e.h2 = v.h2; e.lat = 6 + k;
      sb.push_back(e);
      frame_clk = 1'b1;
      rise_cyc  = cyc;
      for (int j = 1; j <= 40 && sb.size() != 0; j++) begin
         @(negedge sys_clk);
         if (j == 2) frame_clk = 1'b0;
         if (j == 3 + v.d1) p1_done = 1'b1;
         if (j == 3 + v.d2) p2_done = 1'b1;
         if (v.ovr_tick && j == 8) frame_clk = 1'b1;
         if (v.ovr_tick && j == 10) frame_clk = 1'b0;
      end
      if (sb.size() != 0) begin
         chk({tag, "_commit_seen"}, 32'd0, 32'd1);
         sb.delete();
      end
      repeat (3) @(negedge sys_clk);
      chk({tag, "_p1_hit_hold"}, p1_hit, v.h1);
      chk({tag, "_p2_hit_hold"}, p2_hit, v.h2);
      chk({tag, "_calc_timeout"}, calc_timeout, v.tmo);
      chk({tag, "_frame_overrun"}, frame_overrun, v.ovr);
   endtask

   task automatic tick_fast();
      @(negedge sys_clk);
      frame_clk = 1'b1;
      repeat (2) @(negedge sys_clk);
      frame_clk = 1'b0;
      repeat (2) @(negedge sys_clk);
   endtask

   task automatic check_start_regs(input string tag);
      chk({tag, "_p1_state"}, p1_state, NOTHING);
      chk({tag, "_p2_state"}, p2_state, NOTHING);
      chk({tag, "_p1_sprite"}, p1_sprite, 0);
      chk({tag, "_p2_sprite"}, p2_sprite, 0);
      chk({tag, "_p1_pos"}, p1_pos, 100);
      chk({tag, "_p2_pos"}, p2_pos, 500);
   endtask

   task automatic play_round(input int s1, input int s2, input int exp1, input int exp2,
                             input string tag);
      int rs0;
      run_frame(mk(s1, 0, 130, s2, 3, 400, 2, 1, 0, 0, 0, 0, 0), tag);
      chk({tag, "_p1_score"}, p1_score, exp1);
      chk({tag, "_p2_score"}, p2_score, exp2);
      chk({tag, "_round_over"}, round_over, 1);
      rs0 = rs_cnt;
      repeat (59) tick_fast();
      chk({tag, "_round_over_59"}, round_over, 1);
      chk({tag, "_no_early_start"}, rs_cnt - rs0, 0);
      tick_fast();
      repeat (4) @(negedge sys_clk);
      chk({tag, "_round_start_pulse"}, rs_cnt - rs0, 1);
      chk({tag, "_round_over_done"}, round_over, 0);
      chk({tag, "_no_overrun"}, frame_overrun, 0);
      check_start_regs({tag, "_restart"});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = mk(NOTHING, 0, 100, NOTHING, 0, 500, 4, 4, 0, 0, 0, 0, 0);
      tbl[1]  = mk(KICK, 2, 100, NOTHING, 0, 194, 2, 3, 0, 1, 0, 0, 0);
      tbl[2]  = mk(KICK, 2, 100, BLOCK, 0, 194, 1, 0, 0, 0, 0, 0, 0);
      tbl[3]  = mk(KICK, 2, 100, KICK, 2, 174, 0, 5, 0, 0, 0, 0, 0);
      tbl[4]  = mk(GRAB, 1, 100, BLOCK, 0, 169, 3, 3, 0, 1, 0, 0, 0);
      tbl[5]  = mk(KICK, 2, 200, NOTHING, 0, 304, 2, 2, 0, 1, 0, 0, 0);
      tbl[6]  = mk(KICK, 2, 200, NOTHING, 0, 305, 2, 2, 0, 0, 0, 0, 0);
      tbl[7]  = mk(KICK, 1, 100, NOTHING, 0, 194, 1, 1, 0, 0, 0, 0, 0);
      tbl[8]  = mk(NOTHING, 0, 100, KICK, 2, 184, 6, 2, 0, 0, 1, 0, 0);
      tbl[9]  = mk(GRAB, 1, 100, NOTHING, 0, 172, 2, 2, 0, 1, 0, 0, 0);
      tbl[10] = mk(GRAB, 1, 100, NOTHING, 0, 173, 2, 2, 0, 0, 0, 0, 0);
      tbl[11] = mk(NOTHING, 0, 300, GRAB, 1, 320, 2, 2, 0, 0, 1, 0, 0);
      tbl[12] = mk(NOTHING, 0, 110, NOTHING, 0, 480, 1, NEVER, 1, 0, 0, 1, 1);
      tbl[13] = mk(KICK, 2, 100, NOTHING, 0, 150, 2, 2, 0, 1, 0, 1, 1);

      repeat (3) @(negedge sys_clk);
      check_start_regs("reset");
      chk("reset_p1_score", p1_score, 0);
      chk("reset_round_over", round_over, 0);
      chk("reset_flags", {calc_timeout, frame_overrun, p1_hit, p2_hit, frame_commit}, 0);
      reset = 1'b1;
      repeat (2) @(negedge sys_clk);

      for (int i = 0; i < 14; i++) run_frame(tbl[i], $sformatf("vec%0d", i));

      // Sticky flags clear only on reset.
      reset = 1'b0;
      repeat (2) @(negedge sys_clk);
      chk("rst2_sticky", {calc_timeout, frame_overrun}, 0);
      check_start_regs("rst2");
      reset = 1'b1;
      repeat (2) @(negedge sys_clk);

      play_round(WIN, LOSE, 1, 0, "p1_win");
      play_round(LOSE, WIN, 1, 1, "p2_win");
      play_round(WIN, WIN, 1, 1, "both_win");
      for (int n = 2; n <= 15; n++) play_round(WIN, LOSE, n, 1, $sformatf("p1_win%0d", n));
      play_round(WIN, LOSE, 15, 1, "p1_saturate");

      // Reset while in ROUND_END must take effect without a clock edge.
      run_frame(mk(WIN, 0, 130, LOSE, 0, 400, 2, 2, 0, 0, 0, 0, 0), "pre_rst");
      repeat (3) tick_fast();
      chk("pre_rst_round_over", round_over, 1);
      @(negedge sys_clk);
      reset = 1'b0;
      #2;
      chk("async_rst_round_over", round_over, 0);
      chk("async_rst_p1_score", p1_score, 0);
      chk("async_rst_p2_score", p2_score, 0);
      check_start_regs("async_rst");
      @(negedge sys_clk);
      reset = 1'b1;
      repeat (2) @(negedge sys_clk);
      run_frame(tbl[1], "post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
